issue_rat_freelist_bitmap: RTL and testbench

- Parametrised successor PRF free list for the issue-stage RAT.
- Stores free state as a bit-vector and tags speculative allocations with per-FGR (branch checkpoint) masks.
- Abandoning an FGR returns all of its PRFs to the free pool in a single cycle; there is no serial drain through a FIFO.
- Sits between rename (acquire), retire (redeem) and branch resolution (commit/abandon).

---
 rtl/issue_rat_freelist_bitmap.sv | 134 +++++++++++++
 tb/tb_issue_rat_freelist_bitmap.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_rat_freelist_bitmap.sv
// Bit-vector PRF free list with per-FGR speculative allocation masks for the issue-stage RAT.
// Optional free-count output enabled by defining ISSUE_RAT_FREELIST_COUNT_EN.

module issue_rat_fgr_slot #(
    parameter int PRF_COUNT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 tag,
    input  logic [PRF_COUNT-1:0] acq_oh,
    input  logic [PRF_COUNT-1:0] red_oh,
    output logic [PRF_COUNT-1:0] mask
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      mask <= '0;
        else if (clear) mask <= '0;
        else            mask <= (mask & ~red_oh) | (tag ? acq_oh : '0);
    end
endmodule

module issue_rat_freelist_bitmap #(
    parameter  int PRF_COUNT = 64,
    parameter  int FGR_COUNT = 16,
    parameter  int RESERVED  = 32,
    localparam int PW        = $clog2(PRF_COUNT),
    localparam int FW        = $clog2(FGR_COUNT),
    localparam int CW        = $clog2(PRF_COUNT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [PW-1:0] i_redeemed_prf,
    input  logic          i_redeemed_valid,
    output logic          o_redeemed_ready,
    output logic [PW-1:0] o_acquire_prf,
    output logic          o_acquire_ready,
    input  logic [FW-1:0] i_acquire_fgr,
    input  logic          i_acquire_fgr_speculative,
    input  logic          i_acquire_valid,
    input  logic [FW-1:0] i_commit_fgr,
    input  logic          i_commit_valid,
    input  logic [FW-1:0] i_abandon_fgr,
    input  logic          i_abandon_valid,
    output logic          o_double_free
`ifdef ISSUE_RAT_FREELIST_COUNT_EN
    ,
    output logic [CW-1:0] o_free_count
`endif
);
    localparam logic [PRF_COUNT-1:0] FREE_INIT = {PRF_COUNT{1'b1}} << RESERVED;

    logic [PRF_COUNT-1:0]                free_vec, free_n, acq_oh, red_oh, ab_mask;
    logic [FGR_COUNT-1:0][PRF_COUNT-1:0] fgr_mask;
    logic [PW-1:0]                       enc;
    logic                                rdy_q, err_q;
    logic                                acq_fire, red_fire, red_dup, spec_tag;

    // Lowest free index wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        enc = '0;
        for (int i = PRF_COUNT - 1; i >= 0; i--)
            if (free_vec[i]) enc = PW'(i);
    end

    assign o_acquire_prf    = enc;
    assign o_acquire_ready  = |free_vec;
    assign o_redeemed_ready = rdy_q;
    assign o_double_free    = err_q;

    assign acq_fire = i_acquire_valid & o_acquire_ready;
    assign red_fire = i_redeemed_valid & o_redeemed_ready;
    assign red_dup  = red_fire & free_vec[i_redeemed_prf];
    assign spec_tag = acq_fire & i_acquire_fgr_speculative;

    // A double-free redeem is dropped so it can never resurrect a PRF acquired this cycle.
    always_comb begin
        acq_oh  = '0;
        red_oh  = '0;
        ab_mask = '0;
        if (acq_fire) acq_oh[enc] = 1'b1;
        if (red_fire && !red_dup) red_oh[i_redeemed_prf] = 1'b1;
        if (i_abandon_valid) begin
            ab_mask = fgr_mask[i_abandon_fgr];
            if (spec_tag && i_acquire_fgr == i_abandon_fgr) ab_mask = ab_mask | acq_oh;
        end
    end

    assign free_n = (free_vec & ~acq_oh) | red_oh | ab_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            free_vec <= FREE_INIT;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            free_vec <= free_n;
            rdy_q    <= 1'b1;
            if (red_dup) err_q <= 1'b1;
        end
    end

    for (genvar f = 0; f < FGR_COUNT; f++) begin : g_fgr
        issue_rat_fgr_slot #(.PRF_COUNT(PRF_COUNT)) u_slot (
            .clk    (clk),
            .reset  (reset),
            .clear  ((i_abandon_valid && i_abandon_fgr == FW'(f)) ||
                     (i_commit_valid  && i_commit_fgr  == FW'(f))),
            .tag    (spec_tag && i_acquire_fgr == FW'(f)),
            .acq_oh (acq_oh),
            .red_oh (red_oh),
            .mask   (fgr_mask[f])
        );
    end

`ifdef ISSUE_RAT_FREELIST_COUNT_EN
    logic [PRF_COUNT-1:0] gain;
    logic [CW-1:0]        count_q;

    function automatic logic [CW-1:0] popcnt(input logic [PRF_COUNT-1:0] v);
        popcnt = '0;
        for (int i = 0; i < PRF_COUNT; i++) popcnt = popcnt + CW'(v[i]);
    endfunction

    // Only bits that actually transition to free count, so overlaps never double count.
    assign gain = (red_oh | ab_mask) & ~(free_vec & ~acq_oh);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= CW'(PRF_COUNT - RESERVED);
        else       count_q <= count_q - CW'(acq_fire) + popcnt(gain);
    end

    assign o_free_count = count_q;
`endif
endmodule

// File: tb/tb_issue_rat_freelist_bitmap.sv
// Scoreboard bench for issue_rat_freelist_bitmap: a set/tag reference model predicts each
// cycle's outputs into a queue that a negedge monitor drains and compares.

module tb_issue_rat_freelist_bitmap;
    localparam int PRF_COUNT = 64;
    localparam int FGR_COUNT = 16;
    localparam int RESERVED  = 32;
    localparam int PW        = $clog2(PRF_COUNT);
    localparam int FW        = $clog2(FGR_COUNT);
    localparam int CW        = $clog2(PRF_COUNT + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] i_redeemed_prf = '0;
    logic          i_redeemed_valid = 1'b0;
    logic          o_redeemed_ready;
    logic [PW-1:0] o_acquire_prf;
    logic          o_acquire_ready;
    logic [FW-1:0] i_acquire_fgr = '0;
    logic          i_acquire_fgr_speculative = 1'b0;
    logic          i_acquire_valid = 1'b0;
    logic [FW-1:0] i_commit_fgr = '0;
    logic          i_commit_valid = 1'b0;
    logic [FW-1:0] i_abandon_fgr = '0;
    logic          i_abandon_valid = 1'b0;
    logic          o_double_free;
`ifdef ISSUE_RAT_FREELIST_COUNT_EN
    logic [CW-1:0] o_free_count;
`endif

    always #5 clk = ~clk;

    issue_rat_freelist_bitmap #(
        .PRF_COUNT(PRF_COUNT), .FGR_COUNT(FGR_COUNT), .RESERVED(RESERVED)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .i_redeemed_prf            (i_redeemed_prf),
        .i_redeemed_valid          (i_redeemed_valid),
        .o_redeemed_ready          (o_redeemed_ready),
        .o_acquire_prf             (o_acquire_prf),
        .o_acquire_ready           (o_acquire_ready),
        .i_acquire_fgr             (i_acquire_fgr),
        .i_acquire_fgr_speculative (i_acquire_fgr_speculative),
        .i_acquire_valid           (i_acquire_valid),
        .i_commit_fgr              (i_commit_fgr),
        .i_commit_valid            (i_commit_valid),
        .i_abandon_fgr             (i_abandon_fgr),
        .i_abandon_valid           (i_abandon_valid),
        .o_double_free             (o_double_free)
`ifdef ISSUE_RAT_FREELIST_COUNT_EN
        ,
        .o_free_count              (o_free_count)
`endif
    );

    typedef struct {
        int prf;
        int ardy;
        int rrdy;
        int dfree;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: which PRFs are free, and which FGR (or -1) owns each allocated PRF.
    bit mfree[PRF_COUNT];
    int mtag[PRF_COUNT];
    bit mrdy, merr;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < PRF_COUNT; i++) if (mfree[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PRF_COUNT; i++) begin
            mfree[i] = (i >= RESERVED);
            mtag[i]  = -1;
        end
        mrdy = 1'b0;
        merr = 1'b0;
    endtask

    // Applies one cycle of the handshake rules to the model using the inputs present at the edge.
    task automatic model_update();
        int p, r;
        bit acq, red;
        p   = lowest_free();
        acq = i_acquire_valid && (p >= 0);
        red = i_redeemed_valid && mrdy;
        r   = int'(i_redeemed_prf);
        if (red) begin
            if (mfree[r]) merr = 1'b1;
            else begin
                mfree[r] = 1'b1;
                mtag[r]  = -1;
            end
        end
        if (acq) begin
            mfree[p] = 1'b0;
            mtag[p]  = i_acquire_fgr_speculative ? int'(i_acquire_fgr) : -1;
        end
        if (i_abandon_valid)
            for (int i = 0; i < PRF_COUNT; i++)
                if (mtag[i] == int'(i_abandon_fgr)) begin
                    mfree[i] = 1'b1;
                    mtag[i]  = -1;
                end
        if (i_commit_valid)
            for (int i = 0; i < PRF_COUNT; i++)
                if (mtag[i] == int'(i_commit_fgr)) mtag[i] = -1;
        mrdy = 1'b1;
    endtask

    task automatic push_exp();
        exp_t e;
        int p, c;
        p = lowest_free();
        c = 0;
        for (int i = 0; i < PRF_COUNT; i++) c += int'(mfree[i]);
        e.prf   = (p < 0) ? 0 : p;
        e.ardy  = (p >= 0) ? 1 : 0;
        e.rrdy  = int'(mrdy);
        e.dfree = int'(merr);
        e.cnt   = c;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        i_redeemed_valid          = 1'b0;
        i_acquire_valid           = 1'b0;
        i_acquire_fgr_speculative = 1'b0;
        i_commit_valid            = 1'b0;
        i_abandon_valid           = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        push_exp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        clear_inputs();
        #1;
        model_reset();
        push_exp();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("acquire_ready", int'(o_acquire_ready), e.ardy);
            check("acquire_prf", int'(o_acquire_prf), e.prf);
            check("redeemed_ready", int'(o_redeemed_ready), e.rrdy);
            check("double_free", int'(o_double_free), e.dfree);
`ifdef ISSUE_RAT_FREELIST_COUNT_EN
            check("free_count", int'(o_free_count), e.cnt);
`endif
        end
    end

    initial begin
        int idx, budget;

        // Reset release
        do_reset();
        check("rrdy_before_edge", int'(o_redeemed_ready), 0);
        check("prf_after_reset", int'(o_acquire_prf), RESERVED);
        step();
        check("rrdy_after_edge", int'(o_redeemed_ready), 1);

        // Drain the pool in order, then refill one via redeem
        for (int i = 0; i < PRF_COUNT - RESERVED; i++) begin
            check("drain_order", int'(o_acquire_prf), RESERVED + i);
            i_acquire_valid = 1'b1;
            step();
        end
        step();
        check("empty_ready", int'(o_acquire_ready), 0);
        clear_inputs();
        i_redeemed_prf   = PW'(5);
        i_redeemed_valid = 1'b1;
        step();
        clear_inputs();
        check("refill_prf", int'(o_acquire_prf), 5);

        // Abandon frees all PRFs of one FGR at once
        do_reset();
        step();
        i_acquire_valid = 1'b1; i_acquire_fgr_speculative = 1'b1; i_acquire_fgr = FW'(3);
        step();
        step();
        i_acquire_fgr = FW'(4);
        step();
        clear_inputs();
        check("spec_prf", int'(o_acquire_prf), 35);
        i_abandon_valid = 1'b1; i_abandon_fgr = FW'(3);
        step();
        clear_inputs();
        check("abandon_prf", int'(o_acquire_prf), 32);
        i_acquire_valid = 1'b1;
        step();
        step();
        clear_inputs();
        check("fgr4_kept", int'(o_acquire_prf), 35);

        // Same-cycle acquire/commit/abandon, then commit-only
        do_reset();
        step();
        i_acquire_valid = 1'b1; i_acquire_fgr_speculative = 1'b1; i_acquire_fgr = FW'(7);
        i_commit_valid = 1'b1; i_commit_fgr = FW'(7);
        i_abandon_valid = 1'b1; i_abandon_fgr = FW'(7);
        step();
        i_abandon_valid = 1'b0;
        check("abandon_wins", int'(o_acquire_prf), 32);
        step();
        clear_inputs();
        check("commit_alloc", int'(o_acquire_prf), 33);
        i_abandon_valid = 1'b1; i_abandon_fgr = FW'(7);
        step();
        clear_inputs();
        check("commit_sticks", int'(o_acquire_prf), 33);

        // Double free is sticky and leaves the pool alone
        do_reset();
        step();
        i_redeemed_prf = PW'(40); i_redeemed_valid = 1'b1;
        step();
        clear_inputs();
        check("double_free_set", int'(o_double_free), 1);
        step();
        step();
        check("double_free_sticky", int'(o_double_free), 1);
        check("double_free_prf", int'(o_acquire_prf), 32);

        // Random mixed traffic with occasional mid-operation reset
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            clear_inputs();
            if ($urandom_range(99) < 60) begin
                i_acquire_valid = 1'b1;
                i_acquire_fgr_speculative = $urandom_range(1);
                i_acquire_fgr = FW'($urandom_range(FGR_COUNT - 1));
            end
            if ($urandom_range(99) < 45) begin
                idx = $urandom_range(PRF_COUNT - 1);
                if (!mfree[idx]) begin
                    i_redeemed_prf   = PW'(idx);
                    i_redeemed_valid = 1'b1;
                end
            end
            if ($urandom_range(99) < 8) begin
                i_commit_valid = 1'b1; i_commit_fgr = FW'($urandom_range(FGR_COUNT - 1));
            end
            if ($urandom_range(99) < 8) begin
                i_abandon_valid = 1'b1; i_abandon_fgr = FW'($urandom_range(FGR_COUNT - 1));
            end
            if ($urandom_range(1999) == 0) do_reset();
            else step();
        end
        clear_inputs();
        step();

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
